// File: rtl/i2c_frame_sequencer_if.sv
// Handshake and status bundle between a frame requester and the I2C frame sequencer.
`timescale 1ns/1ps

interface i2c_frame_sequencer_if #(
    parameter int unsigned LW = 8
) ();
    logic          start;
    logic [LW-1:0] len;
    logic          tick;
    logic          abort;
    logic          sda_in;
    logic          busy;
    logic [2:0]    phase;
    logic [2:0]    bit_idx;
    logic [LW-1:0] byte_idx;
    logic          ack_stb;
    logic          ack_err;
    logic          done;

    modport master (
        output start, len, tick, abort, sda_in,
        input  busy, phase, bit_idx, byte_idx, ack_stb, ack_err, done
    );

    modport slave (
        input  start, len, tick, abort, sda_in,
        output busy, phase, bit_idx, byte_idx, ack_stb, ack_err, done
    );
endinterface

// File: rtl/i2c_frame_sequencer.sv
// I2C frame sequencer: walks START, 8 data bits + ACK per byte, STOP, paced by a bit-rate tick.
`timescale 1ns/1ps

module i2c_frame_sequencer #(
    parameter int unsigned MAX_BYTES    = 8,
    parameter bit          STOP_ON_NACK = 1'b1,
    parameter int unsigned LW           = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    i2c_frame_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_ACK   = 3'd3,
        S_STOP  = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic          busy_q, busy_d;
    logic [2:0]    bit_q, bit_d;
    logic [LW-1:0] byte_q, byte_d;
    logic [LW-1:0] len_q, len_d;
    logic          ack_stb_q, ack_stb_d;
    logic          ack_err_q, ack_err_d;
    logic          done_q, done_d;

    // State and output registers; async active-high reset abandons any frame in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            bit_q     <= 3'd7;
            byte_q    <= '0;
            len_q     <= '0;
            ack_stb_q <= 1'b0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            len_q     <= len_d;
            ack_stb_q <= ack_stb_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
        end
    end

    // Next-state and next-output logic; ABORT outranks TICK in every busy data-path state.
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        len_d     = len_q;
        ack_err_d = ack_err_q;
        ack_stb_d = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The DONE cycle still belongs to the finished frame, so START is not taken then.
                if (bus.start && !done_q) begin
                    state_d   = S_START;
                    len_d     = (bus.len > LW'(MAX_BYTES)) ? LW'(MAX_BYTES) : bus.len;
                    ack_err_d = 1'b0;
                    byte_d    = '0;
                    bit_d     = 3'd7;
                end
            end
            S_START: begin
                if (bus.abort) begin
                    state_d = S_STOP;
                end else if (bus.tick) begin
                    state_d = (len_q == '0) ? S_STOP : S_DATA;
                end
            end
            S_DATA: begin
                if (bus.abort) begin
                    state_d = S_STOP;
                end else if (bus.tick) begin
                    if (bit_q == 3'd0) begin
                        state_d = S_ACK;
                        bit_d   = 3'd7;
                    end else begin
                        bit_d   = bit_q - 3'd1;
                    end
                end
            end
            S_ACK: begin
                if (bus.abort) begin
                    state_d = S_STOP;
                end else if (bus.tick) begin
                    ack_stb_d = 1'b1;
                    if (bus.sda_in) begin
                        ack_err_d = 1'b1;
                    end
                    if (bus.sda_in && STOP_ON_NACK) begin
                        state_d = S_STOP;
                    end else if (byte_q == len_q - LW'(1)) begin
                        state_d = S_STOP;
                    end else begin
                        byte_d  = byte_q + LW'(1);
                        state_d = S_DATA;
                    end
                end
            end
            S_STOP: begin
                if (bus.tick) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign bus.busy     = busy_q;
    assign bus.phase    = state_q;
    assign bus.bit_idx  = bit_q;
    assign bus.byte_idx = byte_q;
    assign bus.ack_stb  = ack_stb_q;
    assign bus.ack_err  = ack_err_q;
    assign bus.done     = done_q;

endmodule
